regfile_write_arbiter: RTL and testbench
========================================

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, meaning accelerator write-queue depth in entries (power of two).
REQ-002 The block SHALL have parameter STARVE_LIMIT, default 8, meaning consecutive CPU-granted cycles with a non-empty queue before a forced accelerator grant.
REQ-003 clock  in  1  single clock; all state updates on the rising edge.
REQ-004 ctrl_reset_n  in  1  asynchronous, active-low reset.
REQ-005 cpu_wen  in  1  CPU writeback write request.
REQ-006 cpu_wreg  in  5  CPU destination register index.
REQ-007 cpu_wdata  in  32  CPU write data.
REQ-008 cpu_stall  out  1  CPU writeback not accepted this cycle; CPU holds cpu_wen/cpu_wreg/cpu_wdata stable.
REQ-009 acc_valid  in  1  accelerator write request valid.
REQ-010 acc_wreg  in  5  accelerator destination register index.
REQ-011 acc_wdata  in  32  accelerator write data.
REQ-012 acc_ready  out  1  queue can accept an accelerator request.
REQ-013 ctrl_writeEnable  out  1  register-file write enable, registered.
REQ-014 ctrl_writeReg  out  5  register-file write index, registered.
REQ-015 data_writeReg  out  32  register-file write data, registered.
REQ-016 acc_pending  out  log2(FIFO_DEPTH)+1  current queue occupancy.

Function
REQ-017 Accelerator requests SHALL enter a FIFO of FIFO_DEPTH entries {wreg, wdata}; a push occurs on a rising edge when acc_valid && acc_ready.
REQ-018 acc_ready SHALL equal (acc_pending < FIFO_DEPTH) while ctrl_reset_n is high; there is no push-while-full bypass, even when a pop occurs in the same cycle.
REQ-019 An entry pushed at edge N SHALL NOT be popped before edge N+1; there is no empty-queue bypass.
REQ-020 Grant SHALL be decided combinationally each cycle.
- If cpu_wen && !cpu_stall: the CPU is granted.
- Else if the queue is non-empty: the queue head is granted and popped at the next edge.
- Else: no grant.
REQ-021 cpu_stall SHALL equal (starve_cnt == STARVE_LIMIT) && queue non-empty && cpu_wen.
REQ-022 The starve_cnt register SHALL update as follows.
- Increments at the edge when the CPU is granted and the queue is non-empty.
- Clears to 0 when the queue head is granted or the queue is empty.
- Saturates at STARVE_LIMIT.
REQ-023 At the edge following a grant, ctrl_writeReg and data_writeReg SHALL load the granted index and data, and ctrl_writeEnable SHALL load 1 unless the index is 0.
REQ-024 Without a grant, ctrl_writeEnable SHALL load 0, and ctrl_writeReg and data_writeReg SHALL hold their previous values.
REQ-025 Latency SHALL be one cycle: a CPU write sampled at edge N drives the write port during cycle N..N+1, and the register file commits it at edge N+1.
REQ-026 Writes to index 0 SHALL be consumed (popped or accepted) but never produce ctrl_writeEnable=1.
REQ-027 Queue order SHALL be strict FIFO; CPU and accelerator writes to the same index commit in grant order, with no merging or reordering.
REQ-028 Occupancy SHALL update per edge as follows.
- Push and pop in the same edge: acc_pending unchanged.
- Push only: acc_pending increments.
- Pop only: acc_pending decrements.
- Pointers wrap modulo FIFO_DEPTH.

Reset
REQ-029 While ctrl_reset_n is low, the block SHALL asynchronously drive the following.
- Outputs: ctrl_writeEnable=0, ctrl_writeReg=0, data_writeReg=0, acc_pending=0, acc_ready=0, cpu_stall=0.
- Internal state: starve_cnt=0; FIFO pointers cleared.
REQ-030 Reset assertion mid-operation SHALL discard all queued entries, and any write not yet presented on the port is lost.
REQ-031 After the first rising edge with ctrl_reset_n high, acc_ready SHALL be 1.

Verification
REQ-032 CPU only: cpu_wen=1, cpu_wreg=5, cpu_wdata=0xDEADBEEF at edge N -> ctrl_writeEnable=1, ctrl_writeReg=5, data_writeReg=0xDEADBEEF in the following cycle, cpu_stall=0 throughout.
REQ-033 Accelerator into an idle port: acc push {23, 0x00000010} at edge N, cpu_wen=0 -> acc_pending=1 after N, pop at N+1, ctrl_writeEnable=1 with ctrl_writeReg=23 after N+1, acc_pending=0.
REQ-034 Full queue: 4 pushes with cpu_wen held 1 -> acc_ready=0 and acc_pending=4, and a 5th request is not accepted even in the cycle the head pops.
REQ-035 Starvation: queue non-empty and cpu_wen=1 continuously -> after 8 CPU grants, cpu_stall=1 for exactly one cycle, one accelerator entry is written, and starve_cnt returns to 0.
REQ-036 Index 0: CPU write to index 0 and a queued accelerator write to index 0 -> both consumed, ctrl_writeEnable stays 0, and acc_pending decrements.
REQ-037 Mid-operation reset: 3 entries queued, ctrl_reset_n pulsed low between edges -> outputs zero immediately, acc_pending=0, and no queued entry is ever written afterward.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: the CPU writeback has priority over a FIFO of
// accelerator writes. A starvation counter forces one accelerator grant after a CPU run.
module regfile_write_arbiter #(
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                        clock,
  input  logic                        ctrl_reset_n,
  input  logic                        cpu_wen,
  input  logic [4:0]                  cpu_wreg,
  input  logic [31:0]                 cpu_wdata,
  output logic                        cpu_stall,
  input  logic                        acc_valid,
  input  logic [4:0]                  acc_wreg,
  input  logic [31:0]                 acc_wdata,
  output logic                        acc_ready,
  output logic                        ctrl_writeEnable,
  output logic [4:0]                  ctrl_writeReg,
  output logic [31:0]                 data_writeReg,
  output logic [$clog2(FIFO_DEPTH):0] acc_pending
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int SW    = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [SW-1:0]    LIMIT_C = SW'(STARVE_LIMIT);

  typedef struct packed {
    logic [4:0]  wreg;
    logic [31:0] wdata;
  } acc_entry_t;

  acc_entry_t       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wptr, r_rptr;
  logic [CNT_W-1:0] r_count;
  logic [SW-1:0]    r_starve;

  logic        w_empty, w_stall, w_cpu_gnt, w_acc_gnt, w_push;
  logic [4:0]  w_gnt_reg;
  logic [31:0] w_gnt_data;
  acc_entry_t  w_head;

  assign w_empty   = (r_count == '0);
  assign w_head    = r_mem[r_rptr];
  assign w_stall   = (r_starve == LIMIT_C) && !w_empty && cpu_wen;
  assign w_cpu_gnt = cpu_wen && !w_stall;
  assign w_acc_gnt = !w_cpu_gnt && !w_empty;
  // Ready is gated by reset so the queue reads as not-ready while held in reset.
  assign acc_ready = ctrl_reset_n && (r_count < DEPTH_C);
  assign w_push    = acc_valid && acc_ready;

  assign w_gnt_reg  = w_cpu_gnt ? cpu_wreg  : w_head.wreg;
  assign w_gnt_data = w_cpu_gnt ? cpu_wdata : w_head.wdata;

  assign cpu_stall   = w_stall;
  assign acc_pending = r_count;

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wptr] <= '{wreg: acc_wreg, wdata: acc_wdata};
  end

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      r_wptr           <= '0;
      r_rptr           <= '0;
      r_count          <= '0;
      r_starve         <= '0;
      ctrl_writeEnable <= 1'b0;
      ctrl_writeReg    <= '0;
      data_writeReg    <= '0;
    end else begin
      if (w_push)    r_wptr <= (r_wptr == LAST_C) ? '0 : r_wptr + 1'b1;
      if (w_acc_gnt) r_rptr <= (r_rptr == LAST_C) ? '0 : r_rptr + 1'b1;

      case ({w_push, w_acc_gnt})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      // Counts CPU wins against a waiting queue; any queue grant or an empty queue restarts it.
      if (w_cpu_gnt && !w_empty) begin
        if (r_starve != LIMIT_C) r_starve <= r_starve + 1'b1;
      end else if (w_acc_gnt || w_empty) begin
        r_starve <= '0;
      end

      if (w_cpu_gnt || w_acc_gnt) begin
        ctrl_writeEnable <= (w_gnt_reg != 5'd0);
        ctrl_writeReg    <= w_gnt_reg;
        data_writeReg    <= w_gnt_data;
      end else begin
        ctrl_writeEnable <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench: expected writes are queued as stimulus is issued and a negedge monitor
// checks every asserted write-port cycle against them in order.
module tb_regfile_write_arbiter;
  logic        clock = 1'b0;
  logic        ctrl_reset_n;
  logic        cpu_wen;
  logic [4:0]  cpu_wreg;
  logic [31:0] cpu_wdata;
  logic        cpu_stall;
  logic        acc_valid;
  logic [4:0]  acc_wreg;
  logic [31:0] acc_wdata;
  logic        acc_ready;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic [2:0]  acc_pending;

  int checks = 0;
  int errors = 0;
  logic [36:0] exp_q[$];

  regfile_write_arbiter #(.FIFO_DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clock(clock), .ctrl_reset_n(ctrl_reset_n),
    .cpu_wen(cpu_wen), .cpu_wreg(cpu_wreg), .cpu_wdata(cpu_wdata), .cpu_stall(cpu_stall),
    .acc_valid(acc_valid), .acc_wreg(acc_wreg), .acc_wdata(acc_wdata), .acc_ready(acc_ready),
    .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
    .data_writeReg(data_writeReg), .acc_pending(acc_pending)
  );

  always #5 clock = ~clock;

  // Write-port monitor
  always @(negedge clock) begin
    if (ctrl_reset_n === 1'b1 && ctrl_writeEnable === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got reg=%0d data=%h, required no write",
                 ctrl_writeReg, data_writeReg);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        if ({ctrl_writeReg, data_writeReg} !== e) begin
          errors++;
          $display("FAIL write_port: got reg=%0d data=%h, required reg=%0d data=%h",
                   ctrl_writeReg, data_writeReg, e[36:32], e[31:0]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_wr(input logic [4:0] r, input logic [31:0] d);
    exp_q.push_back({r, d});
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_we"},      64'(ctrl_writeEnable), 64'd0);
    chk({tag, "_wreg"},    64'(ctrl_writeReg),    64'd0);
    chk({tag, "_wdata"},   64'(data_writeReg),    64'd0);
    chk({tag, "_pending"}, 64'(acc_pending),      64'd0);
    chk({tag, "_ready"},   64'(acc_ready),        64'd0);
    chk({tag, "_stall"},   64'(cpu_stall),        64'd0);
  endtask

  initial begin
    ctrl_reset_n = 1'b0;
    cpu_wen = 1'b0; cpu_wreg = '0; cpu_wdata = '0;
    acc_valid = 1'b0; acc_wreg = '0; acc_wdata = '0;

    // Reset state, before and after clock edges
    #3;
    chk_zero_outputs("rst_async");
    #20;
    chk_zero_outputs("rst_held");
    #4 ctrl_reset_n = 1'b1;
    tick();
    chk("post_rst_ready", 64'(acc_ready), 64'd1);
    chk("post_rst_pending", 64'(acc_pending), 64'd0);

    // CPU-only write
    cpu_wen = 1'b1; cpu_wreg = 5'd5; cpu_wdata = 32'hDEADBEEF;
    expect_wr(5'd5, 32'hDEADBEEF);
    chk("cpu_stall_pre", 64'(cpu_stall), 64'd0);
    tick();
    cpu_wen = 1'b0;
    chk("cpu_stall_post", 64'(cpu_stall), 64'd0);
    chk("cpu_we", 64'(ctrl_writeEnable), 64'd1);
    tick();
    chk("cpu_we_drop", 64'(ctrl_writeEnable), 64'd0);

    // Accelerator into an idle port: no empty-queue bypass
    acc_valid = 1'b1; acc_wreg = 5'd23; acc_wdata = 32'h00000010;
    expect_wr(5'd23, 32'h00000010);
    tick();
    acc_valid = 1'b0;
    chk("acc_pending_1", 64'(acc_pending), 64'd1);
    chk("acc_no_bypass", 64'(ctrl_writeEnable), 64'd0);
    tick();
    chk("acc_pending_0", 64'(acc_pending), 64'd0);
    chk("acc_we", 64'(ctrl_writeEnable), 64'd1);
    chk("acc_wreg", 64'(ctrl_writeReg), 64'd23);
    tick();

    // Full queue under continuous CPU traffic, then forced accelerator grant
    for (int k = 1; k <= 9; k++) expect_wr(5'd1, 32'h100 + 32'(k));
    expect_wr(5'd10, 32'hA0);
    expect_wr(5'd1, 32'h10A);
    expect_wr(5'd11, 32'hA1);
    expect_wr(5'd12, 32'hA2);
    expect_wr(5'd13, 32'hA3);
    expect_wr(5'd14, 32'hA4);
    for (int e = 1; e <= 11; e++) begin
      cpu_wen   = 1'b1;
      cpu_wreg  = 5'd1;
      cpu_wdata = (e <= 9) ? 32'h100 + 32'(e) : 32'h10A;
      acc_valid = 1'b1;
      acc_wreg  = (e <= 4) ? 5'(9 + e) : 5'd14;
      acc_wdata = (e <= 4) ? 32'hA0 + 32'(e - 1) : 32'hA4;
      if (e == 9)  chk("starve_stall_early", 64'(cpu_stall), 64'd0);
      if (e == 10) begin
        chk("starve_stall", 64'(cpu_stall), 64'd1);
        chk("full_ready_at_pop", 64'(acc_ready), 64'd0);
        chk("full_pending_at_pop", 64'(acc_pending), 64'd4);
      end
      if (e == 11) chk("starve_stall_once", 64'(cpu_stall), 64'd0);
      tick();
      if (e == 4) begin
        chk("full_ready", 64'(acc_ready), 64'd0);
        chk("full_pending", 64'(acc_pending), 64'd4);
      end
      if (e == 10) begin
        chk("after_pop_pending", 64'(acc_pending), 64'd3);
        chk("after_pop_ready", 64'(acc_ready), 64'd1);
      end
    end
    cpu_wen = 1'b0; acc_valid = 1'b0;
    chk("refill_pending", 64'(acc_pending), 64'd4);
    repeat (4) tick();
    chk("drain_pending", 64'(acc_pending), 64'd0);
    tick();

    // Index 0 writes are consumed silently
    cpu_wen = 1'b1; cpu_wreg = 5'd0; cpu_wdata = 32'h55;
    acc_valid = 1'b1; acc_wreg = 5'd0; acc_wdata = 32'h66;
    tick();
    cpu_wen = 1'b0; acc_valid = 1'b0;
    chk("idx0_cpu_we", 64'(ctrl_writeEnable), 64'd0);
    chk("idx0_pending_1", 64'(acc_pending), 64'd1);
    tick();
    chk("idx0_acc_we", 64'(ctrl_writeEnable), 64'd0);
    chk("idx0_pending_0", 64'(acc_pending), 64'd0);
    tick();

    // Mid-operation reset with three queued entries
    for (int e = 1; e <= 3; e++) begin
      cpu_wen = 1'b1; cpu_wreg = 5'd2; cpu_wdata = 32'h200 + 32'(e);
      acc_valid = 1'b1; acc_wreg = 5'(20 + e); acc_wdata = 32'h300 + 32'(e);
      expect_wr(5'd2, 32'h200 + 32'(e));
      tick();
    end
    cpu_wen = 1'b0; acc_valid = 1'b0;
    chk("pre_rst_pending", 64'(acc_pending), 64'd3);
    @(negedge clock);
    #2 ctrl_reset_n = 1'b0;
    #1 chk_zero_outputs("mid_rst");
    #1 ctrl_reset_n = 1'b1;
    repeat (8) tick();
    chk("post_mid_rst_pending", 64'(acc_pending), 64'd0);
    chk("post_mid_rst_ready", 64'(acc_ready), 64'd1);
    chk("post_mid_rst_we", 64'(ctrl_writeEnable), 64'd0);

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
